// File: rtl/posit_pack_arbiter.sv
// Round-robin arbiter sharing one external combinational posit packer among NREQ producers.
// Operands are captured with seed clamping, packed, and returned tagged with the requester id.
module posit_pack_arbiter #(
  parameter int BITS = 32,
  parameter int ES   = 3,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BITS-1:0] req_frac,
  input  logic [NREQ*ES-1:0]   req_exp,
  input  logic [NREQ*BITS-1:0] req_seed,
  input  logic [NREQ-1:0]      req_zero,
  output logic [BITS-1:0]      pk_frac,
  output logic [ES-1:0]        pk_exp,
  output logic [BITS-1:0]      pk_seed,
  output logic                 pk_zero,
  input  logic [BITS-1:0]      pk_posit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS-1:0]      out_posit,
  output logic [IDW-1:0]       out_id,
  output logic                 out_sat,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic signed [BITS-1:0] SEED_MAX = BITS'(BITS - 2);
  localparam logic signed [BITS-1:0] SEED_MIN = -SEED_MAX;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end else begin
      sum = sum;
    end
    return sum[IDW-1:0];
  endfunction

  // Returns {saturated, clamped seed} with the seed limited to +/-(BITS-2).
  function automatic logic [BITS:0] clamp_seed(input logic [BITS-1:0] seed);
    logic signed [BITS-1:0] s;
    s = $signed(seed);
    if (s > SEED_MAX) begin
      return {1'b1, SEED_MAX};
    end else if (s < SEED_MIN) begin
      return {1'b1, SEED_MIN};
    end else begin
      return {1'b0, seed};
    end
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [IDW-1:0]      rr_ptr_r;
  logic [IDW-1:0]      winner_s;
  logic                found_s;
  logic                grant_en_s;
  logic                accept_s;
  logic [BITS:0]       clamp_s;
  logic [BITS-1:0]     op_frac_r;
  logic [ES-1:0]       op_exp_r;
  logic [BITS-1:0]     op_seed_r;
  logic                op_zero_r;
  logic                op_sat_r;
  logic [IDW-1:0]      op_id_r;

  // Round-robin winner search starting at rr_ptr.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req_valid[wrap_idx(rr_ptr_r, k)]) begin
        found_s  = 1'b1;
        winner_s = wrap_idx(rr_ptr_r, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant_en_s = !reset && ((state_r == IDLE) || ((state_r == OUT) && out_ready));
  assign accept_s   = grant_en_s && found_s;
  assign clamp_s    = clamp_seed(req_seed[winner_s*BITS +: BITS]);

  // State register; busy is registered from the next state so it tracks state != IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = PACK;
        else          state_nxt_s = IDLE;
      end
      PACK: state_nxt_s = OUT;
      OUT: begin
        if (!out_ready)    state_nxt_s = OUT;
        else if (accept_s) state_nxt_s = PACK;
        else               state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One-hot grant to the winner, only in cycles where an accept can happen.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      req_ready = '0;
    end
  end

  // Operand capture at accept, result capture in PACK, output handshake in OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r  <= '0;
      op_frac_r <= '0;
      op_exp_r  <= '0;
      op_seed_r <= '0;
      op_zero_r <= 1'b0;
      op_sat_r  <= 1'b0;
      op_id_r   <= '0;
      out_valid <= 1'b0;
      out_posit <= '0;
      out_id    <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (accept_s) begin
        op_frac_r <= req_frac[winner_s*BITS +: BITS];
        op_exp_r  <= req_exp[winner_s*ES +: ES];
        op_seed_r <= clamp_s[BITS-1:0];
        op_sat_r  <= clamp_s[BITS];
        op_zero_r <= req_zero[winner_s];
        op_id_r   <= winner_s;
        rr_ptr_r  <= wrap_idx(winner_s, 32'd1);
      end
      case (state_r)
        PACK: begin
          out_posit <= pk_posit;
          out_id    <= op_id_r;
          out_sat   <= op_sat_r;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= out_valid;
        end
      endcase
    end
  end

  assign pk_frac = op_frac_r;
  assign pk_exp  = op_exp_r;
  assign pk_seed = op_seed_r;
  assign pk_zero = op_zero_r;

endmodule

// File: tb/tb_posit_pack_arbiter.sv
// Bench for posit_pack_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level model of the arbiter and a reference packer.
module tb_posit_pack_arbiter;
  localparam int BITS = 32;
  localparam int ES   = 3;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BITS-1:0] req_frac;
  logic [NREQ*ES-1:0]   req_exp;
  logic [NREQ*BITS-1:0] req_seed;
  logic [NREQ-1:0]      req_zero;
  logic [BITS-1:0]      pk_frac;
  logic [ES-1:0]        pk_exp;
  logic [BITS-1:0]      pk_seed;
  logic                 pk_zero;
  logic [BITS-1:0]      pk_posit;
  logic                 out_valid;
  logic                 out_ready;
  logic [BITS-1:0]      out_posit;
  logic [IDW-1:0]       out_id;
  logic                 out_sat;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  posit_pack_arbiter #(.BITS(BITS), .ES(ES), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_frac(req_frac), .req_exp(req_exp), .req_seed(req_seed), .req_zero(req_zero),
    .pk_frac(pk_frac), .pk_exp(pk_exp), .pk_seed(pk_seed), .pk_zero(pk_zero),
    .pk_posit(pk_posit),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit),
    .out_id(out_id), .out_sat(out_sat), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference posit encoding: sign 0, regime run, ES exponent bits, fraction, truncated.
  function automatic logic [31:0] ref_pack(input logic zero, input int k,
                                           input logic [2:0] e, input logic [31:0] f);
    logic [127:0] regime;
    logic [127:0] val;
    int rlen;
    if (zero) return 32'd0;
    if (k >= 0) begin
      regime = ((128'd1 << (k + 1)) - 128'd1) << 1;
      rlen   = k + 2;
    end else begin
      regime = 128'd1;
      rlen   = 1 - k;
    end
    val = (regime << 35) | (128'(e) << 32) | 128'(f);
    return {1'b0, 31'(val >> (rlen + 35 - 31))};
  endfunction

  assign pk_posit = ref_pack(pk_zero, $signed(pk_seed), pk_exp, pk_frac);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Transaction-level model state.
  bit          m_pack, m_ov;
  int          m_rr, m_w, m_w2;
  int          m_pk_id, m_pk_seed, m_out_id;
  bit          m_pk_zero, m_pk_sat, m_out_sat;
  logic [2:0]  m_pk_exp;
  logic [31:0] m_pk_frac, m_out_posit;

  function automatic int m_pick();
    if (reset || m_pack || (m_ov && !out_ready)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pack = 1'b0;
      m_ov   = 1'b0;
      m_rr   = 0;
    end else begin
      m_w = m_pick();
      if (m_pack) begin
        m_ov        = 1'b1;
        m_out_posit = ref_pack(m_pk_zero, m_pk_seed, m_pk_exp, m_pk_frac);
        m_out_id    = m_pk_id;
        m_out_sat   = m_pk_sat;
        m_pack      = 1'b0;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (m_w >= 0) begin
        m_pk_id   = m_w;
        m_pk_frac = req_frac[m_w*BITS +: BITS];
        m_pk_exp  = req_exp[m_w*ES +: ES];
        m_pk_zero = req_zero[m_w];
        m_pk_seed = $signed(req_seed[m_w*BITS +: BITS]);
        m_pk_sat  = (m_pk_seed > 30) || (m_pk_seed < -30);
        if (m_pk_seed > 30) m_pk_seed = 30;
        if (m_pk_seed < -30) m_pk_seed = -30;
        m_rr   = (m_w + 1) % NREQ;
        m_pack = 1'b1;
      end
    end
  end

  always begin
    @(negedge clk);
    #3;
    m_w2 = m_pick();
    check_val("ready", 32'(req_ready), (m_w2 < 0) ? 32'd0 : (32'd1 << m_w2));
    check_val("busy", 32'(busy), 32'(m_pack || m_ov));
    check_val("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check_val("out_posit", out_posit, m_out_posit);
      check_val("out_id", 32'(out_id), 32'(m_out_id));
      check_val("out_sat", 32'(out_sat), 32'(m_out_sat));
    end
    if (m_pack) begin
      check_val("pk_seed", pk_seed, 32'(m_pk_seed));
      check_val("pk_exp", 32'(pk_exp), 32'(m_pk_exp));
      check_val("pk_frac", pk_frac, m_pk_frac);
      check_val("pk_zero", 32'(pk_zero), 32'(m_pk_zero));
    end
  end

  task automatic set_req(input int i, input logic [31:0] seed, input logic zero,
                         input logic [2:0] e, input logic [31:0] f);
    req_seed[i*BITS +: BITS] = seed;
    req_frac[i*BITS +: BITS] = f;
    req_exp[i*ES +: ES]      = e;
    req_zero[i]              = zero;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Single request from an idle arbiter with out_ready held high.
  task automatic run_one(input int id, input logic [31:0] seed, input logic zero,
                         input logic [31:0] exp_seed, input logic [31:0] exp_posit,
                         input logic exp_sat);
    @(negedge clk);
    req_zero  = '0;
    set_req(id, seed, zero, 3'd0, 32'd0);
    req_valid = '0;
    req_valid[id] = 1'b1;
    out_ready = 1'b1;
    #3 check_val("one_grant", 32'(req_ready), 32'd1 << id);
    @(negedge clk);
    req_valid = '0;
    #3;
    check_val("one_pack_ov", 32'(out_valid), 32'd0);
    check_val("one_pk_seed", pk_seed, exp_seed);
    @(negedge clk);
    #3;
    check_val("one_ov", 32'(out_valid), 32'd1);
    check_val("one_posit", out_posit, exp_posit);
    check_val("one_id", 32'(out_id), 32'(id));
    check_val("one_sat", 32'(out_sat), 32'(exp_sat));
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; req_valid = '0; req_frac = '0; req_exp = '0; req_seed = '0;
    req_zero = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_ov", 32'(out_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_posit", out_posit, 32'd0);
    check_val("rst_id", 32'(out_id), 32'd0);
    check_val("rst_sat", 32'(out_sat), 32'd0);
    check_val("rst_pk_seed", pk_seed, 32'd0);
    check_val("rst_pk_frac", pk_frac, 32'd0);
    check_val("rst_pk_misc", {28'd0, pk_exp, pk_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;

    // Basic packing and seed clamping / zero forwarding
    run_one(0, 32'd0, 1'b0, 32'd0, 32'h4000_0000, 1'b0);
    run_one(0, 32'd1, 1'b0, 32'd1, 32'h6000_0000, 1'b0);
    run_one(0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h2000_0000, 1'b0);
    run_one(1, 32'd40, 1'b0, 32'd30, 32'h7FFF_FFFF, 1'b1);
    run_one(3, 32'hFFFF_FFD8, 1'b0, 32'hFFFF_FFE2, 32'h0000_0001, 1'b1);
    run_one(2, 32'd5, 1'b1, 32'd5, 32'h0000_0000, 1'b0);

    // Round-robin with all requesters valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 2), 1'b0, 3'(i), 32'(i * 7));
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3 check_val("rr_order", 32'(req_ready), 32'd1 << order[i]);
      @(negedge clk);
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Backpressure
    req_zero = '0;
    set_req(0, 32'd7, 1'b0, 3'd0, 32'd0);
    req_valid = 4'b0001;
    out_ready = 1'b0;
    @(negedge clk);
    set_req(1, 32'd9, 1'b0, 3'd0, 32'd0);
    req_valid = 4'b0010;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #3;
      check_val("bp_ready", 32'(req_ready), 32'd0);
      check_val("bp_ov", 32'(out_valid), 32'd1);
      check_val("bp_posit", out_posit, 32'h7F80_0000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #3 check_val("bp_release", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Reset in PACK, then in OUT; rr_ptr must return to 0
    do_reset();
    out_ready = 1'b0;
    set_req(1, 32'd3, 1'b0, 3'd0, 32'd0);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #3;
    check_val("t6_pack_ov", 32'(out_valid), 32'd0);
    check_val("t6_pack_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    #3 check_val("t6_in_out", 32'(out_valid), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #3;
    check_val("t6_out_ov", 32'(out_valid), 32'd0);
    check_val("t6_out_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req_valid = 4'b1010;
    #3 check_val("t6_rr", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        set_req(i,
                ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom_range(0, 80)) - 32'd40),
                ($urandom_range(0, 7) == 0), 3'($urandom), 32'($urandom));
      end
    end
    @(negedge clk);
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
